// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop synchroniser, PRESCALE-times oversampling with
// a 3-sample majority vote, LSB-first deserialiser with parity/stop checking.
module uart_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_data_in,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] parallel_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  busy
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] C_S0  = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] C_S1  = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] C_DEC = CW'(PRESCALE / 2 + 1);
  localparam logic [CW-1:0] C_END = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t                r_state;
  state_t                w_next;
  logic                  r_sync1;
  logic                  r_rx_s;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_s0;
  logic                  r_s1;
  logic                  r_par_en;
  logic                  r_par_type;
  logic                  r_par_err;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_perr;
  logic                  r_serr;

  logic w_decide;
  logic w_bit_end;
  logic w_vote;
  logic w_exp_par;

  assign w_decide  = (r_cnt == C_DEC);
  assign w_bit_end = (r_cnt == C_END);
  assign w_vote    = maj3(r_s0, r_s1, r_rx_s);
  assign w_exp_par = r_par_type ? ~^r_shift : ^r_shift;

  // Synchroniser idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= serial_data_in;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (!r_rx_s) w_next = S_START;
      S_START: begin
        if (w_decide && w_vote) w_next = S_IDLE;
        else if (w_bit_end)     w_next = S_DATA;
      end
      S_DATA:      if (w_bit_end && (r_bit == B_LAST)) w_next = r_par_en ? S_PARITY : S_STOP;
      S_PARITY:    if (w_bit_end) w_next = S_STOP;
      // Leave half a bit early so a back-to-back start bit is not missed
      S_STOP:      if (w_decide) w_next = w_vote ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (r_rx_s) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_par_err  <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_serr     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if ((r_state == S_IDLE) || w_bit_end) r_cnt <= '0;
      else                                  r_cnt <= r_cnt + 1'b1;
      if (r_cnt == C_S0) r_s0 <= r_rx_s;
      if (r_cnt == C_S1) r_s1 <= r_rx_s;

      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_par_en   <= parity_enable;
            r_par_type <= parity_type;
            r_par_err  <= 1'b0;
          end
        end
        S_START: r_bit <= '0;
        S_DATA: begin
          if (w_decide)  r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
          if (w_bit_end) r_bit   <= r_bit + 1'b1;
        end
        S_PARITY: if (w_decide) r_par_err <= (w_vote != w_exp_par);
        S_STOP: begin
          if (w_decide) begin
            r_data  <= r_shift;
            r_perr  <= r_par_err;
            r_serr  <= ~w_vote;
            r_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign parallel_data = r_data;
  assign data_valid    = r_valid;
  assign parity_error  = r_perr;
  assign stop_error    = r_serr;
  assign busy          = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PARITY) || (r_state == S_STOP);

endmodule
